// File: rtl/l15_wakeup_req_stage.sv
// Request stage in front of the L1.5. It holds core requests while the tile sleeps and
// releases them on the PMESH wakeup interrupt, the override strap, or the optional timeout.
module l15_wakeup_req_stage #(
  parameter int                   ReqWidth      = 128,
  parameter int                   RtrnTypeW     = 4,
  parameter logic [RtrnTypeW-1:0] IntRetType    = 4'b0111,
  parameter int                   TimeoutCycles = 32768
) (
  input  logic                 clk_i,
  input  logic                 reset_l,
  input  logic                 wakeup_override_i,
  input  logic                 core_req_val_i,
  input  logic [ReqWidth-1:0]  core_req_i,
  output logic                 core_req_ack_o,
  output logic                 l15_req_val_o,
  output logic [ReqWidth-1:0]  l15_req_o,
  input  logic                 l15_req_ack_i,
  input  logic                 rtrn_val_i,
  input  logic [RtrnTypeW-1:0] rtrn_type_i,
  input  logic [63:0]          rtrn_data0_i,
  output logic                 awake_o,
  output logic                 timeout_o
);

  // A zero-width counter is illegal, so the no-timeout build keeps a 1-bit dummy counter.
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic {
    SLEEP,
    AWAKE
  } state_t;

  state_t          state;
  logic [CntW-1:0] sleep_cnt;
  logic            full;
  logic            wake_hit;
  logic            timeout_hit;
  logic            load;
  logic            unused_rtrn;

  assign wake_hit = rtrn_val_i && (rtrn_type_i == IntRetType) &&
                    (rtrn_data0_i[17:16] == 2'b01) && (rtrn_data0_i[5:0] == 6'b000001);
  assign timeout_hit = (TimeoutCycles != 0) && (sleep_cnt == CntLast);
  assign unused_rtrn = ^{rtrn_data0_i[63:18], rtrn_data0_i[15:6]};

  assign awake_o        = (state == AWAKE);
  assign core_req_ack_o = awake_o && (!full || l15_req_ack_i);
  assign load           = core_req_val_i && core_req_ack_o;
  assign l15_req_val_o  = full;

  // A real wakeup or the strap takes priority, so timeout_o only flags a forced wake.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state     <= SLEEP;
      sleep_cnt <= '0;
      timeout_o <= 1'b0;
    end else if (state == SLEEP) begin
      sleep_cnt <= sleep_cnt + 1'b1;
      if (wake_hit || wakeup_override_i) begin
        state <= AWAKE;
      end else if (timeout_hit) begin
        state     <= AWAKE;
        timeout_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      full      <= 1'b0;
      l15_req_o <= '0;
    end else if (load) begin
      full      <= 1'b1;
      l15_req_o <= core_req_i;
    end else if (l15_req_ack_i) begin
      full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l15_wakeup_req_stage.sv
// Bench for l15_wakeup_req_stage: a default instance plus a short-timeout instance, both
// checked every cycle against a behavioural model, with directed literal checks on top.
module tb_l15_wakeup_req_stage;

  logic         clk = 1'b0;
  logic [1:0]   rst_n;
  logic         override;
  logic         core_val;
  logic [127:0] core_req;
  logic         l15_ack;
  logic         rtrn_val;
  logic [3:0]   rtrn_type;
  logic [63:0]  rtrn_data0;

  logic [1:0]   core_ack;
  logic [1:0]   l15_val;
  logic [1:0]   awake;
  logic [1:0]   tout;
  logic [127:0] l15_req [2];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  l15_wakeup_req_stage dut (
    .clk_i(clk), .reset_l(rst_n[0]), .wakeup_override_i(override),
    .core_req_val_i(core_val), .core_req_i(core_req), .core_req_ack_o(core_ack[0]),
    .l15_req_val_o(l15_val[0]), .l15_req_o(l15_req[0]), .l15_req_ack_i(l15_ack),
    .rtrn_val_i(rtrn_val), .rtrn_type_i(rtrn_type), .rtrn_data0_i(rtrn_data0),
    .awake_o(awake[0]), .timeout_o(tout[0])
  );

  l15_wakeup_req_stage #(.TimeoutCycles(16)) dut_to (
    .clk_i(clk), .reset_l(rst_n[1]), .wakeup_override_i(override),
    .core_req_val_i(core_val), .core_req_i(core_req), .core_req_ack_o(core_ack[1]),
    .l15_req_val_o(l15_val[1]), .l15_req_o(l15_req[1]), .l15_req_ack_i(l15_ack),
    .rtrn_val_i(rtrn_val), .rtrn_type_i(rtrn_type), .rtrn_data0_i(rtrn_data0),
    .awake_o(awake[1]), .timeout_o(tout[1])
  );

  // Model: counts completed sleep cycles and wakes once the count hits the limit.
  for (genvar k = 0; k < 2; k++) begin : g_model
    localparam int Limit = (k == 0) ? 32768 : 16;
    bit           m_awake;
    bit           m_tout;
    bit           m_full;
    int           m_sleep;
    bit [127:0]   m_data;
    bit           m_hit;
    bit           m_tmo;

    always @(posedge clk or negedge rst_n[k]) begin
      if (!rst_n[k]) begin
        m_awake = 1'b0;
        m_tout  = 1'b0;
        m_full  = 1'b0;
        m_sleep = 0;
        m_data  = '0;
      end else if (m_awake) begin
        if (core_val && (!m_full || l15_ack)) begin
          m_full = 1'b1;
          m_data = core_req;
        end else if (l15_ack) begin
          m_full = 1'b0;
        end
      end else begin
        m_hit = rtrn_val && rtrn_type == 4'h7 && rtrn_data0[17:16] == 2'b01 &&
                rtrn_data0[5:0] == 6'd1;
        m_sleep = m_sleep + 1;
        m_tmo = (Limit != 0) && (m_sleep == Limit);
        if (m_hit || override || m_tmo) begin
          m_awake = 1'b1;
          m_tout  = m_tmo && !m_hit && !override;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic checkData(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compareInst(input int k, input bit e_awake, input bit e_tout,
                             input bit e_full, input bit [127:0] e_data);
    checkOutput($sformatf("awake%0d", k), awake[k], e_awake);
    checkOutput($sformatf("timeout%0d", k), tout[k], e_tout);
    checkOutput($sformatf("core_ack%0d", k), core_ack[k], e_awake && (!e_full || l15_ack));
    checkOutput($sformatf("l15_val%0d", k), l15_val[k], e_full);
    if (e_full || !e_awake) checkData($sformatf("l15_req%0d", k), l15_req[k], e_data);
  endtask

  always @(negedge clk) begin
    compareInst(0, g_model[0].m_awake, g_model[0].m_tout, g_model[0].m_full, g_model[0].m_data);
    compareInst(1, g_model[1].m_awake, g_model[1].m_tout, g_model[1].m_full, g_model[1].m_data);
  end

  task automatic applyStimulus(input logic val, input logic [127:0] req, input logic lack);
    core_val = val;
    core_req = req;
    l15_ack  = lack;
  endtask

  task automatic driveRtrn(input logic val, input logic [3:0] typ, input logic [63:0] data);
    rtrn_val   = val;
    rtrn_type  = typ;
    rtrn_data0 = data;
  endtask

  initial begin
    rst_n    = 2'b11;
    override = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    driveRtrn(1'b0, 4'h0, 64'h0);
    #1 rst_n = 2'b00;
    #2;
    checkOutput("rst_awake", awake[0], 1'b0);
    checkOutput("rst_timeout", tout[0], 1'b0);
    checkOutput("rst_core_ack", core_ack[0], 1'b0);
    checkOutput("rst_l15_val", l15_val[0], 1'b0);
    checkData("rst_l15_req", l15_req[0], 128'h0);
    @(negedge clk); #2;
    rst_n[0] = 1'b1;

    $display("[TB] sleeping with a pending request");
    applyStimulus(1'b1, 128'hA5, 1'b0);
    repeat (100) begin
      @(negedge clk);
      checkOutput("t1_core_ack", core_ack[0], 1'b0);
      checkOutput("t1_l15_val", l15_val[0], 1'b0);
      checkOutput("t1_awake", awake[0], 1'b0);
    end

    $display("[TB] wakeup interrupt");
    #2 driveRtrn(1'b1, 4'b0111, 64'h1_0001);
    @(negedge clk);
    checkOutput("t2_awake", awake[0], 1'b1);
    checkOutput("t2_core_ack", core_ack[0], 1'b1);
    #2 driveRtrn(1'b0, 4'h0, 64'h0);
    @(negedge clk);
    checkOutput("t2_l15_val", l15_val[0], 1'b1);
    checkData("t2_l15_req", l15_req[0], 128'hA5);

    $display("[TB] back-pressure");
    #2 applyStimulus(1'b1, 128'h55, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5_core_ack", core_ack[0], 1'b0);
      checkData("t5_l15_req_hold", l15_req[0], 128'hA5);
    end
    #2 applyStimulus(1'b1, 128'h55, 1'b1);
    @(negedge clk);
    checkOutput("t5_l15_val", l15_val[0], 1'b1);
    checkData("t5_reload", l15_req[0], 128'h55);

    $display("[TB] back-to-back requests");
    for (int i = 1; i <= 8; i++) begin
      #2 applyStimulus(1'b1, 128'(i), 1'b1);
      @(negedge clk);
      checkOutput("t4_core_ack", core_ack[0], 1'b1);
      checkData("t4_l15_req", l15_req[0], 128'(i));
    end
    #2 applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("t4_drained", l15_val[0], 1'b0);
    #2 applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] non-matching returns and timeout");
    @(negedge clk); #2;
    rst_n[1] = 1'b1;
    driveRtrn(1'b1, 4'b0111, 64'h1_0002);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checkOutput("t3_awake", awake[1], c == 16);
      checkOutput("t3_timeout", tout[1], c == 16);
      #2;
      if (c == 1) driveRtrn(1'b1, 4'b0000, 64'h1_0001);
      else driveRtrn(1'b0, 4'h0, 64'h0);
    end

    $display("[TB] wakeup coinciding with timeout");
    rst_n[1] = 1'b0;
    @(negedge clk); #2;
    rst_n[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 16) begin
        checkOutput("t3b_awake", awake[1], 1'b1);
        checkOutput("t3b_timeout", tout[1], 1'b0);
      end
      #2;
      if (c == 15) driveRtrn(1'b1, 4'b0111, 64'h1_0001);
      else driveRtrn(1'b0, 4'h0, 64'h0);
    end

    $display("[TB] reset while full");
    applyStimulus(1'b1, 128'hBEEF, 1'b0);
    @(negedge clk);
    checkOutput("t6_full", l15_val[0], 1'b1);
    #2;
    applyStimulus(1'b0, '0, 1'b0);
    rst_n[0] = 1'b0;
    #1;
    checkOutput("t6_async_val", l15_val[0], 1'b0);
    checkOutput("t6_async_awake", awake[0], 1'b0);
    override = 1'b1;
    @(negedge clk); #2;
    rst_n[0] = 1'b1;
    @(negedge clk);
    checkOutput("t6_override_awake", awake[0], 1'b1);
    checkOutput("t6_override_timeout", tout[0], 1'b0);
    #2 override = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
